instr_prefetch_unit: RTL and testbench
======================================

# instr_prefetch_unit

Instruction fetch front-end sitting directly upstream of the multicycle core's IF&ID stage. Issues word-addressed fetches to a variable-latency instruction memory, buffers returned instructions with their PCs in a small in-order FIFO, and hands them to the core on a valid/ready handshake. Branch/JAL redirects from the core flush the buffer, drain stale in-flight responses, and restart fetch at the new target.

## Interface
- `DEPTH`, 4: FIFO entries, which is also the maximum of buffered plus in-flight fetches; power of two, ≥2.
- `RESET_PC`, 16'h0000: first fetch address after reset.
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `imem_req` output 1: fetch request valid.
- `imem_addr` output 16: fetch word address.
- `imem_ready` input 1: memory accepts a request this cycle when high together with `imem_req`.
- `imem_rvalid` input 1: response valid. Responses return in request order, at least 1 cycle after acceptance.
- `imem_rdata` input 16: response instruction word.
- `instr_valid` output 1: FIFO head holds an instruction.
- `instr` output 16: head instruction.
- `instr_pc` output 16: address the head instruction was fetched from.
- `instr_ready` input 1: the core consumes the head when high together with `instr_valid`.
- `redirect` input 1: the core has taken a branch or JAL; flush.
- `redirect_pc` input 16: new fetch target, sampled when `redirect` is high.

## Operation
- State: `fetch_pc` (16 bit), FIFO of {pc, instr} with `count`, `inflight` counter for accepted requests whose responses have not returned, `discard` counter, and an FSM with states RUN and DRAIN.
- Issue: `imem_req` = (state==RUN) && (count + inflight < DEPTH) && !redirect. The address is `fetch_pc`.
- On acceptance (`imem_req && imem_ready`):
  - `inflight` increments.
  - `fetch_pc` becomes `fetch_pc + 1`, mod 2^16, so 16'hFFFF wraps to 16'h0000.
- Response (`imem_rvalid`):
  - `inflight` decrements.
  - If `discard` > 0: the response is dropped and `discard` decrements.
  - Otherwise: push {pc of that request, `imem_rdata`}. The push pc comes from a per-request pc tag carried alongside `inflight`, or equivalently from a separate response-pc counter.
- Pop: when `instr_valid && instr_ready`. The credit rule guarantees a push never overflows; push and pop in the same cycle leave `count` unchanged.
- Redirect (cycle t), taking priority over every other event:
  - FIFO is emptied and any pop is ignored.
  - `discard` is set to the number of responses still outstanding after cycle t. A response arriving in cycle t counts as stale and is not pushed.
  - `fetch_pc` becomes `redirect_pc`.
  - Next state is DRAIN if that outstanding number is > 0, else RUN.
- DRAIN: no requests are issued. Transition to RUN in the cycle after `discard` reaches 0.
- A redirect during DRAIN reloads `fetch_pc` and recomputes `discard`.
- `imem_rvalid` with `inflight`==0 is a protocol error. The bench flags it with an assertion; the RTL ignores it.

## Timing
- Reset values: `imem_req`=0 while reset is asserted; `imem_addr`=`RESET_PC`; `instr_valid`=0; `instr`=0; `instr_pc`=0; state=RUN; all counters 0.
- First request: cycle 1 after reset deassertion, provided `imem_ready`.
- Latency: a response pushed at edge e gives `instr_valid`=1 in the cycle after e. There is no bypass from response to output, so minimum request-to-`instr_valid` is 2 cycles when memory latency is 1.
- Throughput: 1 instruction/cycle sustained when the memory keeps ≤DEPTH requests in flight with a consumer always ready.
- Redirect at t: `instr_valid`=0 at t+1. If nothing is outstanding, the request to `redirect_pc` is issued at t+1.
- Reset asserted mid-operation: everything returns to reset values immediately. Any later stale `imem_rvalid` is treated as a protocol error, so the integrator resets the memory together with this block.

## Configuration
- `PREFETCH_PERF_EN` defined:
  - Adds output ports `perf_fetch_cnt` (16 bit, accepted requests) and `perf_discard_cnt` (16 bit, dropped responses).
  - Both reset to 0, saturate at 16'hFFFF, and update in the same edge as the event they count.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, memory latency 1, `instr_ready`=1 → `instr_pc` sequence 0,1,2,3… with `instr` = memory contents, valid every cycle from cycle 3.
- `instr_ready`=0 with latency 1 → exactly 4 requests issued (addr 0–3), `imem_req` then held low; releasing `instr_ready` pops in order and fetching resumes at addr 4.
- Latency 3, three requests in flight, `redirect`=1 with `redirect_pc`=16'h0020 → FSM enters DRAIN, 3 responses dropped, first delivered `instr_pc`=16'h0020, `perf_discard_cnt`=3 with the macro on.
- Redirect in the same cycle as `imem_rvalid` and pop → FIFO empties, the response is dropped, `count`=0.
- `RESET_PC`=16'hFFFE, consumer always ready → PCs delivered FFFE, FFFF, 0000, 0001.
- Second redirect (to 16'h0040) while in DRAIN from a redirect to 16'h0010 → no instruction from 16'h0010 is ever delivered, first `instr_pc`=16'h0040.

Source files
------------

// File: rtl/instr_prefetch_unit_if.sv
// Instruction prefetch bus bundle: memory fetch port plus core-facing
// instruction handshake and redirect.
//   master (prefetch unit): drives imem_req/imem_addr and instr_valid/instr/instr_pc
//   slave  (memory + core) : drives imem_ready/imem_rvalid/imem_rdata,
//                            instr_ready, redirect/redirect_pc
interface instr_prefetch_unit_if;
  localparam int unsigned XLEN = 16;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_prefetch_unit.sv
// Instruction fetch front-end: issues word fetches to a variable-latency
// memory, buffers {pc, instr} in an in-order FIFO and presents the head to
// the core. A redirect flushes the FIFO, drops stale in-flight responses
// (DRAIN) and restarts fetch at the new target.
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-low reset
//   bus (master)   imem_req/imem_addr/imem_ready/imem_rvalid/imem_rdata,
//                  instr_valid/instr/instr_pc/instr_ready, redirect/redirect_pc
//   perf_fetch_cnt, perf_discard_cnt  saturating event counters, present only
//                  when PREFETCH_PERF_EN is defined
module instr_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_prefetch_unit_if.master bus
`ifdef PREFETCH_PERF_EN
  ,
  output logic [15:0]           perf_fetch_cnt,
  output logic [15:0]           perf_discard_cnt
`endif
);

  localparam int unsigned XLEN = 16;
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  entry_t          fifo_q [DEPTH];

  logic credit_c, req_c, accept_c, rsp_c, drop_c, push_c, pop_c;

  // Credit: buffered plus outstanding fetches never exceed DEPTH, so a push always fits
  assign credit_c = (({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH));
  assign req_c    = reset && (state_q == RUN) && credit_c && !bus.redirect;
  assign accept_c = req_c && bus.imem_ready;
  // Responses with nothing outstanding are a protocol error and are ignored
  assign rsp_c    = bus.imem_rvalid && (inflight_q != '0);
  // A response landing in the redirect cycle is already stale
  assign drop_c   = rsp_c && (bus.redirect || (discard_q != '0));
  assign push_c   = rsp_c && !drop_c;
  assign pop_c    = (count_q != '0) && bus.instr_ready && !bus.redirect;

  assign bus.imem_req    = req_c;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = fifo_q[rptr_q].instr;
  assign bus.instr_pc    = fifo_q[rptr_q].pc;

  // Next-state: normal fetch/response/pop bookkeeping, then redirect override
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;

    if (accept_c) fetch_pc_d = fetch_pc_q + XLEN'(1);
    if (push_c) begin
      resp_pc_d = resp_pc_q + XLEN'(1);
      wptr_d    = wptr_q + AW'(1);
    end
    if (pop_c) rptr_d = rptr_q + AW'(1);
    count_d    = count_q + CW'(push_c) - CW'(pop_c);
    inflight_d = inflight_q + CW'(accept_c) - CW'(rsp_c);
    if (rsp_c && (discard_q != '0)) discard_d = discard_q - CW'(1);

    if ((state_q == DRAIN) && (discard_q == '0)) state_d = RUN;

    // No request is issued during redirect, so outstanding-after = inflight - response
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      resp_pc_d  = bus.redirect_pc;
      count_d    = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      discard_d  = inflight_q - CW'(rsp_c);
      state_d    = (discard_d != '0) ? DRAIN : RUN;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      if (push_c) fifo_q[wptr_q] <= '{pc: resp_pc_q, instr: bus.imem_rdata};
    end
  end

`ifdef PREFETCH_PERF_EN
  logic [XLEN-1:0] perf_fetch_q, perf_discard_q;

  // Saturating counters of accepted requests and dropped responses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_q   <= '0;
      perf_discard_q <= '0;
    end else begin
      if (accept_c && (perf_fetch_q != '1))  perf_fetch_q   <= perf_fetch_q + XLEN'(1);
      if (drop_c && (perf_discard_q != '1))  perf_discard_q <= perf_discard_q + XLEN'(1);
    end
  end

  assign perf_fetch_cnt   = perf_fetch_q;
  assign perf_discard_cnt = perf_discard_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
module tb_instr_prefetch_unit;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  instr_prefetch_unit_if bus ();
  instr_prefetch_unit_if bus_w ();

`ifdef PREFETCH_PERF_EN
  logic [15:0] perf_fetch, perf_discard, perf_fetch_w, perf_discard_w;
`endif

  instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .reset(rst_n), .bus(bus)
`ifdef PREFETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch), .perf_discard_cnt(perf_discard)
`endif
  );

  instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_dut_w (
    .clk(clk), .reset(rst_n), .bus(bus_w)
`ifdef PREFETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_w), .perf_discard_cnt(perf_discard_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed per-address scramble
  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- memory model for the main instance ----------------
  typedef struct {
    logic [15:0] addr;
    int          stamp;
  } req_t;

  req_t mq[$];
  int   cyc;
  int   outstanding;
  int   lat;
  int   gap_pct;
  bit   mem_hold;

  initial begin
    req_t r;
    cyc = 0;
    outstanding = 0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.imem_rvalid) begin
          assert (outstanding > 0) else begin
            failures++;
            $display("FAIL rvalid_protocol actual=rvalid with 0 outstanding required=none");
          end
          outstanding--;
        end
        if (bus.imem_req && bus.imem_ready) begin
          mq.push_back('{bus.imem_addr, cyc});
          outstanding++;
          checks++;
          if (outstanding > int'(DEPTH)) begin
            failures++;
            $display("FAIL credit_bound actual=%0d required<=%0d", outstanding, DEPTH);
          end
        end
      end
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mq.delete();
        outstanding = 0;
      end
      #2;
      bus.imem_rvalid = 1'b0;
      if (rst_n && !mem_hold && (mq.size() > 0) && (cyc >= mq[0].stamp + lat) &&
          (int'($urandom_range(99)) >= gap_pct)) begin
        r = mq.pop_front();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = memf(r.addr);
      end
    end
  end

  // ---------------- latency-1 memory for the wrap instance ----------------
  logic        acc_w;
  logic [15:0] a_w;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
  } del_t;
  del_t w_got[$];

  initial begin
    bus_w.imem_rvalid = 1'b0;
    bus_w.imem_rdata  = 16'h0000;
    forever begin
      @(negedge clk);
      acc_w = rst_n && bus_w.imem_req && bus_w.imem_ready;
      a_w   = bus_w.imem_addr;
      if (rst_n && bus_w.instr_valid && (w_got.size() < 4))
        w_got.push_back('{bus_w.instr_pc, bus_w.instr});
      @(posedge clk);
      #2;
      bus_w.imem_rvalid = acc_w && rst_n;
      bus_w.imem_rdata  = memf(a_w);
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input bit hold);
    rst_n = 1'b0;
    bus.imem_ready  = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    lat      = l;
    gap_pct  = 0;
    mem_hold = hold;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=instr_valid within %0d cycles", name, budget);
    end
  endtask

  // ---------------- directed table: startup, stall, resume ----------------
  typedef struct {
    logic        imem_ready;
    logic        instr_ready;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] wexp;
    bit          redir_prev;
    int          delivered;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus_w.imem_ready  = 1'b1;
    bus_w.instr_ready = 1'b1;
    bus_w.redirect    = 1'b0;
    bus_w.redirect_pc = 16'h0000;

    vt[0]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 16'h0003, 1'b1, 16'h0000};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0000};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0000};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 16'h0000};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 16'h0004, 1'b1, 16'h0000};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0001};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 16'h0005, 1'b1, 16'h0002};
    vt[10] = '{1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0003};
    vt[11] = '{1'b1, 1'b1, 1'b1, 16'h0007, 1'b1, 16'h0004};

    // Reset values, sampled while reset is held
    bus.imem_ready  = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    lat = 1; gap_pct = 0; mem_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check16("rst_req",     16'(bus.imem_req),    16'h0);
    check16("rst_addr",    bus.imem_addr,        16'h0000);
    check16("rst_valid",   16'(bus.instr_valid), 16'h0);
    check16("rst_instr",   bus.instr,            16'h0000);
    check16("rst_pc",      bus.instr_pc,         16'h0000);
    check16("rst_addr_w",  bus_w.imem_addr,      16'hFFFE);
`ifdef PREFETCH_PERF_EN
    check16("rst_perf_fetch",   perf_fetch,   16'h0000);
    check16("rst_perf_discard", perf_discard, 16'h0000);
`endif

    // Table: latency 1, consumer stalled then released
    do_reset(1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      bus.imem_ready  = vt[i].imem_ready;
      bus.instr_ready = vt[i].instr_ready;
      @(negedge clk);
      check16($sformatf("tbl%0d_req", i),   16'(bus.imem_req),    16'(vt[i].exp_req));
      check16($sformatf("tbl%0d_addr", i),  bus.imem_addr,        vt[i].exp_addr);
      check16($sformatf("tbl%0d_valid", i), 16'(bus.instr_valid), 16'(vt[i].exp_valid));
      if (vt[i].exp_valid) begin
        check16($sformatf("tbl%0d_pc", i),    bus.instr_pc, vt[i].exp_pc);
        check16($sformatf("tbl%0d_instr", i), bus.instr,    memf(vt[i].exp_pc));
      end
      step();
    end

    // Wrap instance (RESET_PC=FFFE) streamed during the table run
    checks++;
    if (w_got.size() < 4) begin
      failures++;
      $display("FAIL wrap_count actual=%0d required=4", w_got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        wexp = 16'hFFFE + 16'(k);
        check16($sformatf("wrap%0d_pc", k),    w_got[k].pc,  wexp);
        check16($sformatf("wrap%0d_instr", k), w_got[k].ins, memf(wexp));
      end
    end

    // Latency 3, three in flight, redirect to 0x0020
    do_reset(3, 1'b1);
    repeat (3) step();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0020;
    @(negedge clk);
    check16("drain_req_at_redirect", 16'(bus.imem_req), 16'h0);
    step();
    bus.redirect = 1'b0; mem_hold = 1'b0;
    @(negedge clk);
    check16("drain_valid", 16'(bus.instr_valid), 16'h0);
    check16("drain_req",   16'(bus.imem_req),    16'h0);
    step();
    wait_valid("drain_first", 40);
    check16("drain_first_pc",    bus.instr_pc, 16'h0020);
    check16("drain_first_instr", bus.instr,    memf(16'h0020));
`ifdef PREFETCH_PERF_EN
    check16("perf_discard", perf_discard, 16'h0003);
`endif

    // Redirect coinciding with a response and a pop (latency 1 streaming)
    do_reset(1, 1'b0);
    repeat (5) step();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0100;
    @(negedge clk);
    check16("rp_valid_before", 16'(bus.instr_valid), 16'h1);
    step();
    bus.redirect = 1'b0;
    @(negedge clk);
    check16("rp_valid_after", 16'(bus.instr_valid), 16'h0);
    check16("rp_req_after",   16'(bus.imem_req),    16'h1);
    check16("rp_addr_after",  bus.imem_addr,        16'h0100);
    step();
    wait_valid("rp_first", 20);
    check16("rp_first_pc",    bus.instr_pc, 16'h0100);
    check16("rp_first_instr", bus.instr,    memf(16'h0100));

    // Second redirect while draining from the first
    do_reset(3, 1'b1);
    repeat (3) step();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0010;
    step();
    bus.redirect = 1'b0; mem_hold = 1'b0;
    @(negedge clk);
    check16("dd_req_drain", 16'(bus.imem_req), 16'h0);
    step();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
    step();
    bus.redirect = 1'b0;
    wait_valid("dd_first", 40);
    check16("dd_first_pc",    bus.instr_pc, 16'h0040);
    check16("dd_first_instr", bus.instr,    memf(16'h0040));

    // Randomized run against the delivered-stream model
    do_reset(1, 1'b0);
    exp_pc     = 16'h0000;
    redir_prev = 1'b0;
    delivered  = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (redir_prev) check16("rnd_flush_valid", 16'(bus.instr_valid), 16'h0);
      if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
        check16("rnd_pc",    bus.instr_pc, exp_pc);
        check16("rnd_instr", bus.instr,    memf(exp_pc));
        exp_pc = exp_pc + 16'h1;
        delivered++;
      end
      if (bus.redirect) begin
        check16("rnd_req_in_redirect", 16'(bus.imem_req), 16'h0);
        exp_pc = bus.redirect_pc;
      end
      redir_prev = bus.redirect;
      step();
      if ((c % 1000) == 999) begin
        lat     = (c / 1000) + 2;
        gap_pct = int'($urandom_range(40));
      end
      bus.imem_ready  = ($urandom_range(3) != 0);
      bus.instr_ready = ($urandom_range(3) != 0);
      bus.redirect    = ($urandom_range(24) == 0);
      bus.redirect_pc = 16'($urandom);
    end
    checks++;
    if (delivered < 500) begin
      failures++;
      $display("FAIL rnd_throughput actual=%0d required>=500", delivered);
    end

    // Asynchronous reset mid-operation
    bus.redirect = 1'b0;
    rst_n = 1'b0;
    #1;
    check16("midrst_valid", 16'(bus.instr_valid), 16'h0);
    check16("midrst_req",   16'(bus.imem_req),    16'h0);
    check16("midrst_addr",  bus.imem_addr,        16'h0000);
`ifdef PREFETCH_PERF_EN
    check16("midrst_perf_fetch", perf_fetch, 16'h0000);
`endif
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
